// File: rtl/decoder_pkg.sv
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths, select/one-hot types and the one-hot check
//               function for the binary-to-one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef logic [DEC_IN_W-1:0]  sel_t;
  typedef logic [DEC_OUT_W-1:0] onehot_t;

  function automatic logic onehot_check(input onehot_t v);
    return ($countones(v) == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_core.sv
// ============================================================================
// Module      : decoder_core
// Description : Purely combinational binary-to-one-hot decode of a_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_core #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  a_i,
  output logic [OUT_W-1:0] x_o
);

  // Equality compare per bit so an unknown select propagates as X on every bit.
  always_comb begin
    x_o = '0;
    for (int k = 0; k < OUT_W; k++) begin
      x_o[k] = (a_i == IN_W'(k));
    end
  end

endmodule

`default_nettype wire

// File: rtl/decoder.sv
// ============================================================================
// Module      : decoder
// Description : One-hot decoder with combinational output, a registered copy
//               with valid flag, and an optional sticky one-hot checker
//               enabled by DECODER_ONEHOT_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      a,
  output logic [2**IN_W-1:0]   x,
  output logic [2**IN_W-1:0]   x_q,
  output logic                 x_vld,
  output logic                 err
);

  localparam int OUT_W = 2**IN_W;

  logic [OUT_W-1:0] x_q_d;
  logic             x_vld_q;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .a_i (a),
    .x_o (x)
  );

  assign x_q_d = x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      x_vld_q <= 1'b0;
    end else begin
      x_q     <= x_q_d;
      x_vld_q <= 1'b1;
    end
  end

  assign x_vld = x_vld_q;

`ifdef DECODER_ONEHOT_CHK_EN
  logic err_q;
  logic err_d;
  logic onehot_ok;

  generate
    if (OUT_W == DEC_OUT_W) begin : g_pkg_chk
      assign onehot_ok = onehot_check(onehot_t'(x_q));
    end else begin : g_cnt_chk
      assign onehot_ok = ($countones(x_q) == 1);
    end
  endgenerate

  // Sticky: once a non-one-hot registered value is seen, hold until reset.
  always_comb begin
    err_d = err_q | (x_vld_q & ~onehot_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// ============================================================================
// Module      : tb_decoder
// Description : Directed self-checking bench for decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] a;
  logic [7:0] x;
  logic [7:0] x_q;
  logic       x_vld;
  logic       err;

  int checks;
  int failures;

  decoder #(.IN_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .x     (x),
    .x_q   (x_q),
    .x_vld (x_vld),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written truth table for the 3-to-8 decode.
  logic [7:0] exp_tab [8];
  initial begin
    exp_tab[0] = 8'b0000_0001; exp_tab[1] = 8'b0000_0010;
    exp_tab[2] = 8'b0000_0100; exp_tab[3] = 8'b0000_1000;
    exp_tab[4] = 8'b0001_0000; exp_tab[5] = 8'b0010_0000;
    exp_tab[6] = 8'b0100_0000; exp_tab[7] = 8'b1000_0000;
  end

  task automatic test_reset();
    rst = 1'b1;
    a   = 3'd0;
    @(negedge clk); @(negedge clk);
    checks++; if (x_q !== 8'h00) begin failures++; $display("FAIL reset_x_q actual=%b required=%b", x_q, 8'h00); end
    checks++; if (x_vld !== 1'b0) begin failures++; $display("FAIL reset_x_vld actual=%b required=0", x_vld); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b required=0", err); end
    checks++; if (x !== 8'b0000_0001) begin failures++; $display("FAIL reset_x_comb actual=%b required=00000001", x); end
  endtask

  task automatic test_sweep();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      #1;
      checks++; if (x !== exp_tab[i]) begin failures++; $display("FAIL sweep_x a=%0d actual=%b required=%b", i, x, exp_tab[i]); end
      @(posedge clk); #1;
      checks++; if (x_q !== exp_tab[i]) begin failures++; $display("FAIL sweep_x_q a=%0d actual=%b required=%b", i, x_q, exp_tab[i]); end
      checks++; if (x_vld !== 1'b1) begin failures++; $display("FAIL sweep_x_vld a=%0d actual=%b required=1", i, x_vld); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL sweep_err a=%0d actual=%b required=0", i, err); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    a = 3'd7;
    @(posedge clk); #1;
    checks++; if (x !== 8'b1000_0000) begin failures++; $display("FAIL wrap_x_hi actual=%b required=10000000", x); end
    a = a + 3'd1;
    #1;
    checks++; if (x !== 8'b0000_0001) begin failures++; $display("FAIL wrap_x_lo actual=%b required=00000001", x); end
    @(posedge clk); #1;
    checks++; if (x_q !== 8'b0000_0001) begin failures++; $display("FAIL wrap_x_q actual=%b required=00000001", x_q); end
    @(negedge clk);
  endtask

  task automatic test_registered_path();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a   = 3'b101;
    #1;
    checks++; if (x !== 8'b0010_0000) begin failures++; $display("FAIL reg_x_imm actual=%b required=00100000", x); end
    checks++; if (x_vld !== 1'b0) begin failures++; $display("FAIL reg_vld_pre actual=%b required=0", x_vld); end
    checks++; if (x_q !== 8'h00) begin failures++; $display("FAIL reg_x_q_pre actual=%b required=00000000", x_q); end
    @(posedge clk); #1;
    checks++; if (x_q !== 8'b0010_0000) begin failures++; $display("FAIL reg_x_q actual=%b required=00100000", x_q); end
    checks++; if (x_vld !== 1'b1) begin failures++; $display("FAIL reg_vld actual=%b required=1", x_vld); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    a = 3'b110;
    @(posedge clk); #1;
    checks++; if (x_q !== 8'b0100_0000) begin failures++; $display("FAIL arst_x_q_pre actual=%b required=01000000", x_q); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (x_q !== 8'h00) begin failures++; $display("FAIL arst_x_q actual=%b required=00000000", x_q); end
    checks++; if (x_vld !== 1'b0) begin failures++; $display("FAIL arst_x_vld actual=%b required=0", x_vld); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err actual=%b required=0", err); end
    checks++; if (x !== 8'b0100_0000) begin failures++; $display("FAIL arst_x actual=%b required=01000000", x); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (x_vld !== 1'b1) begin failures++; $display("FAIL arst_vld_resume actual=%b required=1", x_vld); end
    @(negedge clk);
  endtask

  task automatic test_checker();
    logic exp_err;
`ifdef DECODER_ONEHOT_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    force dut.x_q = 8'b0000_0011;
    @(posedge clk); #1;
    checks++; if (err !== exp_err) begin failures++; $display("FAIL chk_err_set actual=%b required=%b", err, exp_err); end
    @(negedge clk);
    release dut.x_q;
    a = 3'd2;
    @(posedge clk); #1;
    checks++; if (x_q !== 8'b0000_0100) begin failures++; $display("FAIL chk_x_q_recover actual=%b required=00000100", x_q); end
    @(posedge clk); #1;
    checks++; if (err !== exp_err) begin failures++; $display("FAIL chk_err_sticky actual=%b required=%b", err, exp_err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_err_clear actual=%b required=0", err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_wrap();
    test_registered_path();
    test_async_reset();
    test_checker();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
